irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter: NUM_SRC, default 8, number of interrupt sources (1..31).
REQ-002 Parameter: BASE_ADDR, default 32'hFFFF_0000, base of the 32-byte register window.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 nReset  in  1  asynchronous, active-low reset.
REQ-005 memaddr  in  32  core data address.
REQ-006 memwrite  in  1  core store strobe.
REQ-007 memread  in  1  core load strobe.
REQ-008 be  in  4  byte enables for writedata lanes.
REQ-009 writedata  in  32  store data.
REQ-010 readdata  out  32  load data; combinational.
REQ-011 hit  out  1  high when memaddr lies in the window; steers the core's readdata mux.
REQ-012 irq_src  in  NUM_SRC  asynchronous peripheral interrupt lines, active-high.
REQ-013 nIRQ  out  1  registered active-low interrupt request to the core.

Function
REQ-014 Window: hit = (memaddr[31:5] == BASE_ADDR[31:5]); the register offset is memaddr[4:2].
REQ-015 Registers: 0x00 RAW (RO pending), 0x04 ENABLE (RW), 0x08 MODE (RW; 1 = edge, 0 = level), 0x0C CLEAR (WO, write-1-to-clear), 0x10 ID (RO), 0x14 EOI (WO).
REQ-016 Writes take effect on the rising edge where memwrite && hit; only byte lanes with be[i] = 1 are updated; unused bits read 0.
REQ-017 Read: readdata = selected register when hit && memread, otherwise 32'h0; CLEAR and EOI read 0.
REQ-018 Each irq_src bit passes through a 2-flop synchronizer; edge mode detects a 0->1 transition of the synchronized value.
REQ-019 Latency: irq_src first sampled high at edge N -> pending set at edge N+2 -> nIRQ low after edge N+3 (if enabled and FSM in IDLE).
REQ-020 Edge mode: pending bit sets on a detected edge and holds until cleared via CLEAR or EOI; set wins over a same-cycle clear.
REQ-021 Level mode: pending = synchronized level; CLEAR has no effect.
REQ-022 active = pending & ENABLE; ID = index of the lowest-numbered active bit in [4:0], bit31 = 1 if none active (ID = 32'h8000_0000).
REQ-023 FSM states: IDLE, ASSERT, SERVICE.
REQ-024 IDLE -> ASSERT when |active; nIRQ registered low in ASSERT.
REQ-025 ASSERT -> SERVICE on a read of ID that returns a valid index; the returned index is latched as cur_id; nIRQ goes high on the same edge.
REQ-026 ASSERT -> IDLE if active drops to 0 (source disabled or cleared) before ID is read.
REQ-027 SERVICE -> IDLE on an EOI write; in edge mode the write clears pending[cur_id]; the written data value is ignored.
REQ-028 In SERVICE, new pending bits accumulate but nIRQ stays high; after EOI, residual active sources re-assert nIRQ one edge later.
REQ-029 An EOI write in IDLE or ASSERT is ignored.
REQ-030 A MODE change on a bit clears that pending bit.

Reset
REQ-031 With nReset low: RAW, ENABLE, MODE, synchronizer flops and cur_id are 0; the FSM is in IDLE; nIRQ = 1; readdata follows REQ-017.
REQ-032 Reset asserted mid-service aborts the service; there is no pending or EOI carry-over after release.

Structure
REQ-033 Package irq_pkg holds: register offsets, the FSM state enum, the ID-none constant 32'h8000_0000, and the default BASE_ADDR.
REQ-034 One sub-module, irq_sync (per-bit 2-flop synchronizer plus rising-edge detector), is instantiated NUM_SRC-wide.

Verification
REQ-035 Reset -> nIRQ = 1; reads of RAW, ENABLE and MODE return 0; a read of ID returns 32'h8000_0000.
REQ-036 ENABLE = 0x05, MODE = 0xFF, pulse irq_src[2] -> nIRQ low at N+3; read of ID = 2; nIRQ high; EOI write -> RAW = 0, IDLE.
REQ-037 With irq_src[0] and irq_src[2] both pending and enabled, edge mode -> ID = 0; EOI -> nIRQ re-asserts one edge later; ID = 2.
REQ-038 Level mode, irq_src[1] held high, ENABLE = 0x02 -> CLEAR write 0x02 leaves RAW[1] = 1; after source drops, RAW[1] = 0 within 2 edges.
REQ-039 Edge on irq_src[3] coincident with CLEAR 0x08 -> RAW[3] = 1 (set wins).
REQ-040 nReset pulsed while in SERVICE -> IDLE, nIRQ = 1, all registers 0; a write of 0x0F to ENABLE with be = 4'b0000 -> ENABLE remains 0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the memory-mapped interrupt controller: register map,
// FSM state encoding, the "no interrupt" ID value and a byte-lane merge helper.
package irq_pkg;

  localparam logic [2:0] OFF_RAW    = 3'd0;
  localparam logic [2:0] OFF_ENABLE = 3'd1;
  localparam logic [2:0] OFF_MODE   = 3'd2;
  localparam logic [2:0] OFF_CLEAR  = 3'd3;
  localparam logic [2:0] OFF_ID     = 3'd4;
  localparam logic [2:0] OFF_EOI    = 3'd5;

  localparam logic [31:0] ID_NONE           = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: two-flop synchronizer followed by a rising-edge detector
// on the synchronized value.
module irq_sync (
  input  logic clk,
  input  logic nReset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-source edge/level pending capture,
// enable masking, lowest-index priority and an ASSERT/SERVICE/EOI handshake.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic [31:0]        memaddr,
  input  logic               memwrite,
  input  logic               memread,
  input  logic [3:0]         be,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               hit,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               nIRQ
);

  localparam int PAD = 32 - NUM_SRC;

  logic [2:0]         off;
  logic               wr_en, rd_en, id_rd, eoi_wr, eoi_fire;
  logic [NUM_SRC-1:0] sync_lvl, sync_rise;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] mode_chg, clr_mask, active;
  logic [31:0]        en_merge, md_merge, clr_merge;
  logic               id_valid;
  logic [4:0]         id_idx;
  logic [31:0]        id_val;
  irq_state_e         state_q, state_d;
  logic [4:0]         cur_id_q, cur_id_d;
  logic               nirq_q, nirq_d;
  logic               unused_ok;

  assign hit    = (memaddr[31:5] == BASE_ADDR[31:5]);
  assign off    = memaddr[4:2];
  assign wr_en  = memwrite && hit;
  assign rd_en  = memread && hit;
  assign id_rd  = rd_en && (off == OFF_ID);
  assign eoi_wr = wr_en && (off == OFF_EOI);
  assign eoi_fire = eoi_wr && (state_q == ST_SERVICE);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync u_sync (
      .clk      (clk),
      .nReset   (nReset),
      .async_in (irq_src[g]),
      .level    (sync_lvl[g]),
      .rise     (sync_rise[g])
    );
  end

  // Register writes and pending capture
  always_comb begin
    en_merge  = be_merge({{PAD{1'b0}}, enable_q}, writedata, be);
    md_merge  = be_merge({{PAD{1'b0}}, mode_q}, writedata, be);
    clr_merge = be_merge(32'h0, writedata, be);
    enable_d  = enable_q;
    mode_d    = mode_q;
    clr_mask  = '0;
    if (wr_en && (off == OFF_ENABLE)) enable_d = en_merge[NUM_SRC-1:0];
    if (wr_en && (off == OFF_MODE))   mode_d   = md_merge[NUM_SRC-1:0];
    if (wr_en && (off == OFF_CLEAR))  clr_mask = clr_merge[NUM_SRC-1:0];
    mode_chg  = mode_d ^ mode_q;
    pending_d = pending_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_chg[i]) begin
        pending_d[i] = 1'b0;
      end else if (!mode_q[i]) begin
        pending_d[i] = sync_lvl[i];
      end else begin
        // A fresh edge outranks any clear arriving in the same cycle.
        pending_d[i] = sync_rise[i] |
                       (pending_q[i] & ~(clr_mask[i] |
                                         (eoi_fire && (cur_id_q == 5'(i)))));
      end
    end
  end

  assign active = pending_q & enable_q;

  always_comb begin
    id_valid = |active;
    id_idx   = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) id_idx = 5'(i);
    end
    id_val = id_valid ? {27'd0, id_idx} : ID_NONE;
  end

  // Request/acknowledge handshake with the core
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (id_valid) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (id_rd && id_valid) begin
          state_d  = ST_SERVICE;
          cur_id_d = id_idx;
        end else if (!id_valid) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    nirq_d = (state_d != ST_ASSERT);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      state_q   <= ST_IDLE;
      cur_id_q  <= 5'd0;
      nirq_q    <= 1'b1;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      nirq_q    <= nirq_d;
    end
  end

  assign nIRQ = nirq_q;

  always_comb begin
    readdata = 32'h0;
    if (rd_en) begin
      case (off)
        OFF_RAW:    readdata = {{PAD{1'b0}}, pending_q};
        OFF_ENABLE: readdata = {{PAD{1'b0}}, enable_q};
        OFF_MODE:   readdata = {{PAD{1'b0}}, mode_q};
        OFF_ID:     readdata = id_val;
        default:    readdata = 32'h0;
      endcase
    end
  end

  assign unused_ok = ^{memaddr[1:0], en_merge[31:NUM_SRC],
                       md_merge[31:NUM_SRC], clr_merge[31:NUM_SRC]};

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset state, edge/level capture, priority,
// EOI handshake, set-over-clear, byte lanes and mid-service reset.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int          NUM  = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic           clk = 1'b0;
  logic           nReset;
  logic [31:0]    memaddr;
  logic           memwrite, memread;
  logic [3:0]     be;
  logic [31:0]    writedata;
  logic [31:0]    readdata;
  logic           hit;
  logic [NUM-1:0] irq_src;
  logic           nIRQ;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rv;

  irq_controller #(.NUM_SRC(NUM), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .memaddr   (memaddr),
    .memwrite  (memwrite),
    .memread   (memread),
    .be        (be),
    .writedata (writedata),
    .readdata  (readdata),
    .hit       (hit),
    .irq_src   (irq_src),
    .nIRQ      (nIRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d, input logic [3:0] b);
    memaddr   = BASE + {27'd0, o, 2'b00};
    writedata = d;
    be        = b;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
    be        = 4'h0;
    writedata = 32'h0;
  endtask

  task automatic peek(input logic [2:0] o, output logic [31:0] d);
    memaddr = BASE + {27'd0, o, 2'b00};
    memread = 1'b1;
    #1;
    d = readdata;
    memread = 1'b0;
  endtask

  task automatic rd_id(output logic [31:0] d);
    memaddr = BASE + {27'd0, OFF_ID, 2'b00};
    memread = 1'b1;
    #1;
    d = readdata;
    @(posedge clk);
    #1;
    memread = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; memaddr = 32'h0; memwrite = 1'b0; memread = 1'b0;
    be = 4'h0; writedata = 32'h0; irq_src = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nirq_in_reset", {31'd0, nIRQ}, 32'd1);
    nReset = 1'b1;
    tick();

    // Reset state
    chk("rst_nirq", {31'd0, nIRQ}, 32'd1);
    peek(OFF_RAW, rv);    chk("rst_raw", rv, 32'h0);
    peek(OFF_ENABLE, rv); chk("rst_enable", rv, 32'h0);
    peek(OFF_MODE, rv);   chk("rst_mode", rv, 32'h0);
    peek(OFF_ID, rv);     chk("rst_id_none", rv, 32'h8000_0000);

    // Address window decode and read gating
    memaddr = BASE + 32'h20; memread = 1'b1; #1;
    chk("hit_outside", {31'd0, hit}, 32'd0);
    chk("rd_outside", readdata, 32'h0);
    memaddr = BASE + 32'h1C; #1;
    chk("hit_top", {31'd0, hit}, 32'd1);
    memaddr = BASE + 32'h10; memread = 1'b0; #1;
    chk("rd_no_strobe", readdata, 32'h0);

    // Single edge source: latency, ID, EOI
    wr(OFF_ENABLE, 32'h05, 4'hF);
    wr(OFF_MODE, 32'hFF, 4'hF);
    peek(OFF_ENABLE, rv); chk("enable_rb", rv, 32'h05);
    peek(OFF_CLEAR, rv);  chk("clear_reads0", rv, 32'h0);
    irq_src = 8'h04; tick();
    irq_src = 8'h00; tick();
    chk("lat_n1_nirq", {31'd0, nIRQ}, 32'd1);
    tick();
    peek(OFF_RAW, rv); chk("lat_n2_raw", rv, 32'h04);
    chk("lat_n2_nirq", {31'd0, nIRQ}, 32'd1);
    tick();
    chk("lat_n3_nirq", {31'd0, nIRQ}, 32'd0);
    rd_id(rv); chk("id_src2", rv, 32'd2);
    chk("svc_nirq_high", {31'd0, nIRQ}, 32'd1);
    peek(OFF_RAW, rv); chk("svc_raw_held", rv, 32'h04);
    wr(OFF_EOI, 32'hDEAD_BEEF, 4'hF);
    chk("eoi_nirq", {31'd0, nIRQ}, 32'd1);
    peek(OFF_RAW, rv); chk("eoi_raw_clr", rv, 32'h0);
    tick();
    chk("idle_nirq", {31'd0, nIRQ}, 32'd1);

    // Two sources: priority and re-assert after EOI
    irq_src = 8'h05; tick();
    irq_src = 8'h00; tick(); tick(); tick();
    chk("two_nirq", {31'd0, nIRQ}, 32'd0);
    rd_id(rv); chk("two_id0", rv, 32'd0);
    chk("two_svc_nirq", {31'd0, nIRQ}, 32'd1);
    wr(OFF_EOI, 32'h0, 4'hF);
    chk("two_eoi_nirq", {31'd0, nIRQ}, 32'd1);
    tick();
    chk("two_reassert", {31'd0, nIRQ}, 32'd0);
    rd_id(rv); chk("two_id2", rv, 32'd2);
    wr(OFF_EOI, 32'h0, 4'hF);
    peek(OFF_RAW, rv); chk("two_raw_clr", rv, 32'h0);

    // Level mode: CLEAR ignored, pending follows source, ASSERT drops
    wr(OFF_MODE, 32'h00, 4'hF);
    wr(OFF_ENABLE, 32'h02, 4'hF);
    irq_src = 8'h02; tick(); tick(); tick();
    peek(OFF_RAW, rv); chk("lvl_raw_set", rv, 32'h02);
    tick();
    chk("lvl_nirq", {31'd0, nIRQ}, 32'd0);
    wr(OFF_CLEAR, 32'h02, 4'hF);
    peek(OFF_RAW, rv); chk("lvl_clear_noeff", rv, 32'h02);
    irq_src = 8'h00; tick(); tick(); tick();
    peek(OFF_RAW, rv); chk("lvl_raw_drop", rv, 32'h0);
    chk("lvl_nirq_still", {31'd0, nIRQ}, 32'd0);
    tick();
    chk("lvl_assert_abort", {31'd0, nIRQ}, 32'd1);

    // Edge coincident with CLEAR: set wins
    wr(OFF_ENABLE, 32'h00, 4'hF);
    wr(OFF_MODE, 32'hFF, 4'hF);
    irq_src = 8'h08; tick(); tick();
    wr(OFF_CLEAR, 32'h08, 4'hF);
    peek(OFF_RAW, rv); chk("set_wins", rv, 32'h08);
    irq_src = 8'h00;
    wr(OFF_CLEAR, 32'h08, 4'hF);
    peek(OFF_RAW, rv); chk("clear_works", rv, 32'h0);

    // Reset during service, then byte-lane gating
    wr(OFF_ENABLE, 32'h08, 4'hF);
    irq_src = 8'h08; tick();
    irq_src = 8'h00; tick(); tick(); tick();
    chk("pre_rst_nirq", {31'd0, nIRQ}, 32'd0);
    rd_id(rv); chk("pre_rst_id3", rv, 32'd3);
    nReset = 1'b0; #1;
    chk("mid_rst_nirq", {31'd0, nIRQ}, 32'd1);
    peek(OFF_ENABLE, rv); chk("mid_rst_enable", rv, 32'h0);
    peek(OFF_MODE, rv);   chk("mid_rst_mode", rv, 32'h0);
    peek(OFF_RAW, rv);    chk("mid_rst_raw", rv, 32'h0);
    tick();
    nReset = 1'b1;
    tick();
    peek(OFF_ID, rv); chk("post_rst_id", rv, 32'h8000_0000);
    wr(OFF_ENABLE, 32'h0F, 4'h0);
    peek(OFF_ENABLE, rv); chk("be_none", rv, 32'h0);
    wr(OFF_ENABLE, 32'h0000_FF0F, 4'h1);
    peek(OFF_ENABLE, rv); chk("be_lane0", rv, 32'h0F);
    tick(); tick();
    chk("no_carryover_nirq", {31'd0, nIRQ}, 32'd1);
    peek(OFF_RAW, rv); chk("no_carryover_raw", rv, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
